// File: rtl/grf_wb_stage_pkg.sv
// Core-wide encodings shared by the controller, MEM stage and WB stage.
package grf_wb_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned CNT_W      = 32;

    // Write-back data source select.
    typedef enum logic [1:0] {
        WDSEL_ALU  = 2'd0,
        WDSEL_MEM  = 2'd1,
        WDSEL_PC8  = 2'd2,
        WDSEL_HILO = 2'd3
    } wdsel_e;

    // Load type; codes 5-7 fall back to a full-word load.
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    localparam logic [REG_AW_DEF-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/grf_wb_stage_load_ext.sv
// Load extension: picks the addressed byte/half of an aligned word and extends it.
module grf_wb_stage_load_ext
    import grf_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] memrd,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        ldtype,
    output logic [DATA_W-1:0] ext_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Byte lane and half lane selection; half ignores addr_lo[0].
    always_comb begin
        sel_byte = memrd[7:0];
        case (addr_lo)
            2'd0:    sel_byte = memrd[7:0];
            2'd1:    sel_byte = memrd[15:8];
            2'd2:    sel_byte = memrd[23:16];
            default: sel_byte = memrd[31:24];
        endcase
        sel_half = addr_lo[1] ? memrd[31:16] : memrd[15:0];
    end

    // Sign/zero extension by load type.
    always_comb begin
        ext_data = memrd;
        case (ldtype)
            LD_B:    ext_data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
            LD_BU:   ext_data = {{(DATA_W-8){1'b0}}, sel_byte};
            LD_H:    ext_data = {{(DATA_W-16){sel_half[15]}}, sel_half};
            LD_HU:   ext_data = {{(DATA_W-16){1'b0}}, sel_half};
            default: ext_data = memrd;
        endcase
    end

endmodule

// File: rtl/grf_wb_stage.sv
// MEM/WB pipeline register plus write-back select, $0 suppression and retire counter.
module grf_wb_stage
    import grf_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] m_pc,
    input  logic              m_regwrite,
    input  logic [REG_AW-1:0] m_rd,
    input  logic [1:0]        m_wdsel,
    input  logic [DATA_W-1:0] m_alu,
    input  logic [DATA_W-1:0] m_memrd,
    input  logic [1:0]        m_addr_lo,
    input  logic [2:0]        m_ldtype,
    input  logic [DATA_W-1:0] m_hilo,
    input  logic              flush,
    output logic              grf_we,
    output logic [REG_AW-1:0] grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              w_valid_q;
    logic [DATA_W-1:0] w_pc_q;
    logic              w_regwrite_q;
    logic [REG_AW-1:0] w_rd_q;
    wdsel_e            w_wdsel_q;
    logic [DATA_W-1:0] w_alu_q;
    logic [DATA_W-1:0] w_memrd_q;
    logic [1:0]        w_addr_lo_q;
    logic [2:0]        w_ldtype_q;
    logic [DATA_W-1:0] w_hilo_q;
    logic [CNT_W-1:0]  retire_cnt_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wd_sel;

    // MEM/WB register: flush captures a bubble and holds the remaining fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_valid_q    <= 1'b0;
            w_pc_q       <= '0;
            w_regwrite_q <= 1'b0;
            w_rd_q       <= '0;
            w_wdsel_q    <= WDSEL_ALU;
            w_alu_q      <= '0;
            w_memrd_q    <= '0;
            w_addr_lo_q  <= '0;
            w_ldtype_q   <= '0;
            w_hilo_q     <= '0;
        end else if (flush) begin
            w_valid_q    <= 1'b0;
        end else begin
            w_valid_q    <= m_valid;
            w_pc_q       <= m_pc;
            w_regwrite_q <= m_regwrite;
            w_rd_q       <= m_rd;
            w_wdsel_q    <= wdsel_e'(m_wdsel);
            w_alu_q      <= m_alu;
            w_memrd_q    <= m_memrd;
            w_addr_lo_q  <= m_addr_lo;
            w_ldtype_q   <= m_ldtype;
            w_hilo_q     <= m_hilo;
        end
    end

    // Retire counter: the instruction sitting in WB retires on every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (w_valid_q) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    grf_wb_stage_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .memrd    (w_memrd_q),
        .addr_lo  (w_addr_lo_q),
        .ldtype   (w_ldtype_q),
        .ext_data (load_data)
    );

    // Write-back data source select.
    always_comb begin
        wd_sel = w_alu_q;
        case (w_wdsel_q)
            WDSEL_ALU:  wd_sel = w_alu_q;
            WDSEL_MEM:  wd_sel = load_data;
            WDSEL_PC8:  wd_sel = w_pc_q + DATA_W'(8);
            WDSEL_HILO: wd_sel = w_hilo_q;
            default:    wd_sel = w_alu_q;
        endcase
    end

    assign grf_we     = w_valid_q & w_regwrite_q & (w_rd_q != REG_AW'(REG_ZERO));
    assign grf_a3     = w_rd_q;
    assign grf_wd     = wd_sel;
    assign grf_pc     = w_pc_q;
    assign fwd_valid  = grf_we;
    assign fwd_rd     = grf_a3;
    assign fwd_data   = grf_wd;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_grf_wb_stage.sv
// Randomized and directed bench for the write-back stage against a behavioural model.
module tb_grf_wb_stage;

    logic        clk;
    logic        rst;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_regwrite;
    logic [4:0]  m_rd;
    logic [1:0]  m_wdsel;
    logic [31:0] m_alu;
    logic [31:0] m_memrd;
    logic [1:0]  m_addr_lo;
    logic [2:0]  m_ldtype;
    logic [31:0] m_hilo;
    logic        flush;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] retire_cnt;

    int total;
    int bad;

    grf_wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .m_valid    (m_valid),
        .m_pc       (m_pc),
        .m_regwrite (m_regwrite),
        .m_rd       (m_rd),
        .m_wdsel    (m_wdsel),
        .m_alu      (m_alu),
        .m_memrd    (m_memrd),
        .m_addr_lo  (m_addr_lo),
        .m_ldtype   (m_ldtype),
        .m_hilo     (m_hilo),
        .flush      (flush),
        .grf_we     (grf_we),
        .grf_a3     (grf_a3),
        .grf_wd     (grf_wd),
        .grf_pc     (grf_pc),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected write data computed from the instruction's semantics.
    function automatic logic [31:0] model_wd(input logic [1:0] sel, input logic [31:0] pc,
                                             input logic [31:0] alu, input logic [31:0] memrd,
                                             input logic [1:0] lo, input logic [2:0] lt,
                                             input logic [31:0] hilo);
        logic [31:0] b;
        logic [31:0] h;
        b = (memrd >> (8 * int'(lo))) & 32'h0000_00FF;
        h = (memrd >> (16 * (int'(lo) / 2))) & 32'h0000_FFFF;
        case (sel)
            2'd0: return alu;
            2'd2: return pc + 32'd8;
            2'd3: return hilo;
            default: begin
                case (lt)
                    3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
                    3'd2:    return b;
                    3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
                    3'd4:    return h;
                    default: return memrd;
                endcase
            end
        endcase
    endfunction

    // Model state: the instruction now in WB and the retire count.
    logic        md_valid;
    logic        md_rw;
    logic [4:0]  md_rd;
    logic [31:0] md_pc;
    logic [31:0] md_wd;
    logic [31:0] md_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_valid = 1'b0; md_rw = 1'b0; md_rd = 5'd0;
            md_pc = 32'd0; md_wd = 32'd0; md_cnt = 32'd0;
        end else begin
            if (md_valid) md_cnt = md_cnt + 32'd1;
            if (flush) begin
                md_valid = 1'b0;
            end else begin
                md_valid = m_valid;
                md_rw    = m_regwrite;
                md_rd    = m_rd;
                md_pc    = m_pc;
                md_wd    = model_wd(m_wdsel, m_pc, m_alu, m_memrd, m_addr_lo, m_ldtype, m_hilo);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_we;
            exp_we = md_valid && md_rw && (md_rd != 5'd0);
            check("we",        32'(grf_we),    32'(exp_we));
            check("a3",        32'(grf_a3),    32'(md_rd));
            check("pc",        grf_pc,         md_pc);
            check("wd",        grf_wd,         md_wd);
            check("fwd_valid", 32'(fwd_valid), 32'(exp_we));
            check("fwd_rd",    32'(fwd_rd),    32'(md_rd));
            check("fwd_data",  fwd_data,       md_wd);
            check("retire",    retire_cnt,     md_cnt);
        end
    end

    // Present one bundle at a negedge; returns at the negedge after it was captured.
    task automatic send(input logic v, input logic [31:0] pc, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] memrd,
                        input logic [1:0] lo, input logic [2:0] lt, input logic [31:0] hilo,
                        input logic fl);
        m_valid = v; m_pc = pc; m_regwrite = rw; m_rd = rd; m_wdsel = sel; m_alu = alu;
        m_memrd = memrd; m_addr_lo = lo; m_ldtype = lt; m_hilo = hilo; flush = fl;
        @(negedge clk);
    endtask

    task automatic bubble();
        send(1'b0, 32'd0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 2'd0, 3'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] c0;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        m_valid = 1'b0; m_pc = '0; m_regwrite = 1'b0; m_rd = '0; m_wdsel = '0; m_alu = '0;
        m_memrd = '0; m_addr_lo = '0; m_ldtype = '0; m_hilo = '0; flush = 1'b0;

        #3;
        check("reset_we",  32'(grf_we), 32'd0);
        check("reset_a3",  32'(grf_a3), 32'd0);
        check("reset_wd",  grf_wd,      32'd0);
        check("reset_pc",  grf_pc,      32'd0);
        check("reset_cnt", retire_cnt,  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Load extension cases.
        send(1'b1, 32'h3000, 1'b1, 5'd8, 2'd1, 32'd0, 32'h8033_7F01, 2'd3, 3'd1, 32'd0, 1'b0);
        check("lb_we", 32'(grf_we), 32'd1);
        check("lb_a3", 32'(grf_a3), 32'd8);
        check("lb_wd", grf_wd, 32'hFFFF_FF80);
        send(1'b1, 32'h3004, 1'b1, 5'd8, 2'd1, 32'd0, 32'h8033_7F01, 2'd3, 3'd2, 32'd0, 1'b0);
        check("lbu_wd", grf_wd, 32'h0000_0080);
        send(1'b1, 32'h3008, 1'b1, 5'd9, 2'd1, 32'd0, 32'h8001_1234, 2'd2, 3'd3, 32'd0, 1'b0);
        check("lh2_wd", grf_wd, 32'hFFFF_8001);
        send(1'b1, 32'h300C, 1'b1, 5'd9, 2'd1, 32'd0, 32'h8001_1234, 2'd3, 3'd3, 32'd0, 1'b0);
        check("lh3_wd", grf_wd, 32'hFFFF_8001);
        send(1'b1, 32'h3010, 1'b1, 5'd9, 2'd1, 32'd0, 32'h8001_1234, 2'd0, 3'd4, 32'd0, 1'b0);
        check("lhu_wd", grf_wd, 32'h0000_1234);

        // Link write.
        send(1'b1, 32'h0000_3004, 1'b1, 5'd31, 2'd2, 32'd0, 32'd0, 2'd0, 3'd0, 32'd0, 1'b0);
        check("jal_wd", grf_wd, 32'h0000_300C);
        check("jal_pc", grf_pc, 32'h0000_3004);
        check("jal_a3", 32'(grf_a3), 32'd31);

        // Write to $0 is suppressed but still retires.
        send(1'b1, 32'h3018, 1'b1, 5'd0, 2'd0, 32'h1234, 32'd0, 2'd0, 3'd0, 32'd0, 1'b0);
        check("r0_we",  32'(grf_we),    32'd0);
        check("r0_fwd", 32'(fwd_valid), 32'd0);
        c0 = retire_cnt;

        // Flush wins over m_valid; the $0 instruction retires on this edge.
        send(1'b1, 32'h301C, 1'b1, 5'd5, 2'd0, 32'h55, 32'd0, 2'd0, 3'd0, 32'd0, 1'b1);
        check("r0_retire", retire_cnt, c0 + 32'd1);
        check("flush_we",  32'(grf_we), 32'd0);
        c0 = retire_cnt;
        bubble();
        check("flush_cnt", retire_cnt, c0);

        // Asynchronous reset mid-cycle while a write is in WB.
        send(1'b1, 32'h3020, 1'b1, 5'd7, 2'd3, 32'd0, 32'd0, 2'd0, 3'd0, 32'hCAFE_F00D, 1'b0);
        check("pre_rst_we", 32'(grf_we), 32'd1);
        check("hilo_wd",    grf_wd,      32'hCAFE_F00D);
        m_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_we",  32'(grf_we), 32'd0);
        check("arst_a3",  32'(grf_a3), 32'd0);
        check("arst_wd",  grf_wd,      32'd0);
        check("arst_pc",  grf_pc,      32'd0);
        check("arst_cnt", retire_cnt,  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1'b1, 32'h4000 + 32'(4 * i), 1'b1, 5'(i + 1), 2'd0, 32'(i), 32'd0, 2'd0, 3'd0, 32'd0, 1'b0);
        bubble();
        check("cnt_after3", retire_cnt, 32'd3);

        // Randomized traffic checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            send(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)), rd,
                 2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 9) == 0));
        end
        bubble();
        bubble();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grf_wb_stage.md
Name: grf_wb_stage

Overview:
- Write-back stage of the pipelined MIPS core; the initiator that drives the register file's write port (we, a3, wd, pc).
- Registers the MEM-stage result bundle (MEM/WB pipeline register).
- Selects and extends the write-back data.
- Suppresses writes to $0, supplies a forwarding tap to earlier stages, and counts retired instructions.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
m_valid  in  1  MEM stage holds a real instruction
m_pc  in  32  PC of the MEM-stage instruction
m_regwrite  in  1  instruction writes the register file
m_rd  in  5  destination register number
m_wdsel  in  2  0=ALU, 1=MEM load, 2=PC+8 (link), 3=HI/LO
m_alu  in  32  ALU result
m_memrd  in  32  raw aligned word from data memory
m_addr_lo  in  2  low two bits of the load address
m_ldtype  in  3  0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu; 5-7 are treated as lw
m_hilo  in  32  HI/LO read value
flush  in  1  capture a bubble instead of the MEM bundle
grf_we  out  1  register-file write enable
grf_a3  out  5  register-file write address
grf_wd  out  32  register-file write data
grf_pc  out  32  PC of the writing instruction, used for the trace display
fwd_valid  out  1  forwarding tap valid; equals grf_we
fwd_rd  out  5  forwarding register number; equals grf_a3
fwd_data  out  32  forwarding data; equals grf_wd
retire_cnt  out  32  count of retired instructions

Behaviour:
- Single register stage with latency 1: the bundle presented at posedge N drives the grf_* outputs during cycle N+1.
- Capture at each posedge:
  - flush=1: w_valid<=0; all other bundle fields are don't-care but are held.
  - flush=0: the whole bundle is captured, with w_valid<=m_valid.
  - There is no stall input. WB never stalls, so upstream must not hold MEM while expecting WB to hold.
- Outputs are combinational from the registered bundle only. There is no combinational path from m_* to grf_*.
- grf_we = w_valid & w_regwrite & (w_rd != 0). A write to $0 is never issued.
- grf_a3 = w_rd and grf_pc = w_pc, regardless of grf_we.
- Data select:
  - ALU: w_alu.
  - HILO: w_hilo.
  - PC+8: w_pc + 8, modulo 2^32.
  - MEM: load-extended data, formed as below.
- Load extension:
  - lw: full word; addr_lo is ignored.
  - lb/lbu: byte = memrd[8*addr_lo +: 8]; lb sign-extends, lbu zero-extends.
  - lh/lhu: half = memrd[16*addr_lo[1] +: 16]; addr_lo[0] is ignored (alignment exceptions are handled upstream); lh sign-extends, lhu zero-extends.
- Forwarding outputs mirror grf_we, grf_a3 and grf_wd exactly, in the same cycle.
- retire_cnt increments by 1 on each posedge where w_valid=1, whether or not the instruction writes a register. It wraps from 0xFFFFFFFF to 0.
- Reset (async, rst=1):
  - w_valid=0, all registered fields=0, retire_cnt=0.
  - Hence grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0 immediately, with no clock needed.
  - Reset mid-operation discards the instruction in WB with no write and no count.
  - The first capture occurs at the first posedge after rst deasserts.
- Simultaneous flush and m_valid=1: flush wins.
- The instruction already in WB still retires on that edge; flush affects only the incoming capture.

Decomposition:
- Shared package (core-wide, also used by the controller and the MEM stage):
  - WDSEL_ALU/MEM/PC8/HILO encodings.
  - LD_W/LD_B/LD_BU/LD_H/LD_HU encodings.
  - REG_ZERO constant.
- One sub-module, load_ext: combinational (memrd, addr_lo, ldtype) -> extended word. It is reused by the MEM-stage forwarding logic.

Test Plan:
- lb: memrd=0x8033_7F01, addr_lo=3, rd=8, regwrite=1 -> next cycle grf_we=1, a3=8, wd=0xFFFF_FF80. Same with lbu -> wd=0x0000_0080.
- lh: memrd=0x8001_1234, addr_lo=2 -> wd=0xFFFF_8001; addr_lo=3 gives the same result; with lhu, addr_lo=0 -> wd=0x0000_1234.
- jal: m_pc=0x0000_3004, wdsel=PC+8, rd=31 -> grf_wd=0x0000_300C, grf_pc=0x0000_3004.
- rd=0, regwrite=1, alu=0x1234 -> grf_we=0 and fwd_valid=0, but retire_cnt still increments.
- flush=1 with m_valid=1 -> next cycle grf_we=0 and retire_cnt unchanged on the following edge.
- rst pulsed mid-cycle while grf_we=1 -> grf_we=0 and retire_cnt=0 before the next edge; 3 valid instructions after release -> retire_cnt=3. Preloading the counter to 0xFFFFFFFF by retiring instructions, or forcing it in the bench, wraps it to 0.
